// File: rtl/load_store_unit.sv
// load_store_unit: scalar (SMRD) and 64-lane vector (MTBUF) memory access path.
// Each accepted instruction produces one tagged memory request on the next cycle.
// A per-wavefront pending table holds what is needed to finish the instruction when
// the memory acknowledges it: register write-back, completion to issue, retirement.
module load_store_unit (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_lsu_select,
    input  logic [11:0]   issue_source_reg1,
    input  logic [11:0]   issue_source_reg2,
    input  logic [11:0]   issue_source_reg3,
    input  logic [11:0]   issue_dest_reg,
    input  logic [11:0]   issue_mem_sgpr,
    input  logic [15:0]   issue_imm_value0,
    input  logic [7:0]    issue_imm_value1,
    input  logic [15:0]   issue_opdcode,
    input  logic [5:0]    issue_wfid,
    input  logic [31:0]   issue_instr_pc,
    input  logic [2047:0] vgpr_source1_data,
    input  logic [2047:0] vgpr_source2_data,
    input  logic [127:0]  sgpr_source1_data,
    input  logic [31:0]   sgpr_source2_data,
    input  logic [63:0]   exec_exec_value,
    input  logic [2047:0] mem_rd_data,
    input  logic [6:0]    mem2lsu_tag,
    input  logic          mem_ack,
    output logic [9:0]    vgpr_source1_addr,
    output logic [9:0]    vgpr_source2_addr,
    output logic [8:0]    sgpr_source1_addr,
    output logic [8:0]    sgpr_source2_addr,
    output logic [5:0]    exec_rd_wfid,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [2047:0] mem_addr,
    output logic [2047:0] mem_wr_data,
    output logic [63:0]   mem_wr_mask,
    output logic [6:0]    lsu2mem_tag,
    output logic [9:0]    vgpr_dest_addr,
    output logic [2047:0] vgpr_dest_data,
    output logic [63:0]   vgpr_dest_wr_mask,
    output logic [8:0]    sgpr_dest_addr,
    output logic [31:0]   sgpr_dest_data,
    output logic          sgpr_dest_wr_en,
    output logic          issue_mem_done,
    output logic [5:0]    issue_mem_done_wfid,
    output logic          issue_ready,
    output logic          tracemon_retire_valid,
    output logic [31:0]   tracemon_retire_pc
);
    localparam logic [7:0] CLASS_SMRD  = 8'h01;
    localparam logic [7:0] CLASS_MTBUF = 8'h02;

    logic          is_smrd_s;
    logic          is_mtbuf_s;
    logic          is_store_s;
    logic          req_valid_s;
    logic [31:0]   imm_s;
    logic [31:0]   vec_base_s;
    logic [2047:0] addr_vec_s;
    logic [5:0]    ack_idx_s;
    logic          ack_hit_s;
    logic          unused_inputs_s;

    // Pending table, one slot per wavefront
    logic [63:0]   pend_valid_r;
    logic          pend_scalar_r [64];
    logic          pend_store_r  [64];
    logic [9:0]    pend_dest_r   [64];
    logic [63:0]   pend_exec_r   [64];
    logic [31:0]   pend_pc_r     [64];

    // Registered outputs
    logic          mem_rd_en_r;
    logic          mem_wr_en_r;
    logic [2047:0] mem_addr_r;
    logic [2047:0] mem_wr_data_r;
    logic [63:0]   mem_wr_mask_r;
    logic [6:0]    lsu2mem_tag_r;
    logic [9:0]    vgpr_dest_addr_r;
    logic [2047:0] vgpr_dest_data_r;
    logic [63:0]   vgpr_dest_wr_mask_r;
    logic [8:0]    sgpr_dest_addr_r;
    logic [31:0]   sgpr_dest_data_r;
    logic          sgpr_dest_wr_en_r;
    logic          issue_mem_done_r;
    logic [5:0]    issue_mem_done_wfid_r;
    logic          issue_ready_r;
    logic          retire_valid_r;
    logic [31:0]   retire_pc_r;

    // Operand fetch addresses go straight out so the register files return data in the select cycle
    assign vgpr_source1_addr = issue_source_reg1[9:0];
    assign vgpr_source2_addr = issue_dest_reg[9:0];
    assign sgpr_source1_addr = issue_mem_sgpr[8:0];
    assign sgpr_source2_addr = issue_source_reg3[8:0];
    assign exec_rd_wfid      = issue_wfid;

    // Fields the unit never looks at (register-file type bits, second immediate, op bits other than store)
    assign unused_inputs_s = ^{issue_source_reg1[11:10], issue_source_reg2, issue_source_reg3[11:9],
                               issue_dest_reg[11:10], issue_mem_sgpr[11:9], issue_imm_value1,
                               issue_opdcode[7:3], issue_opdcode[1:0], sgpr_source1_data[127:32],
                               mem2lsu_tag[6]};

    // Decode the instruction class; anything unknown is silently dropped
    always_comb begin
        is_smrd_s  = 1'b0;
        is_mtbuf_s = 1'b0;
        is_store_s = 1'b0;
        case (issue_opdcode[15:8])
            CLASS_SMRD:  is_smrd_s = 1'b1;
            CLASS_MTBUF: begin
                is_mtbuf_s = 1'b1;
                is_store_s = issue_opdcode[2];
            end
            default: begin
                is_smrd_s  = 1'b0;
                is_mtbuf_s = 1'b0;
            end
        endcase
    end

    assign req_valid_s = issue_lsu_select & (is_smrd_s | is_mtbuf_s);
    assign imm_s       = {16'd0, issue_imm_value0};
    assign vec_base_s  = sgpr_source1_data[31:0] + sgpr_source2_data + imm_s;

    // Address generation: scalar uses lane 0 only, vector adds the per-lane offset to a shared base
    always_comb begin
        addr_vec_s = '0;
        if (is_smrd_s) begin
            addr_vec_s[31:0] = sgpr_source1_data[31:0] + imm_s;
        end else if (is_mtbuf_s) begin
            for (int i = 0; i < 64; i++) begin
                addr_vec_s[32*i +: 32] = vec_base_s + vgpr_source1_data[32*i +: 32];
            end
        end else begin
            addr_vec_s = '0;
        end
    end

    // Memory request register: one-cycle strobe following each accepted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en_r   <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_addr_r    <= '0;
            mem_wr_data_r <= '0;
            mem_wr_mask_r <= 64'd0;
            lsu2mem_tag_r <= 7'd0;
        end else if (req_valid_s) begin
            mem_rd_en_r   <= ~is_store_s;
            mem_wr_en_r   <= is_store_s;
            mem_addr_r    <= addr_vec_s;
            mem_wr_data_r <= is_store_s ? vgpr_source2_data : '0;
            mem_wr_mask_r <= is_smrd_s ? 64'h1 : exec_exec_value;
            lsu2mem_tag_r <= {~is_store_s, issue_wfid};
        end else begin
            mem_rd_en_r   <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_addr_r    <= '0;
            mem_wr_data_r <= '0;
            mem_wr_mask_r <= 64'd0;
            lsu2mem_tag_r <= 7'd0;
        end
    end

    assign ack_idx_s = mem2lsu_tag[5:0];
    assign ack_hit_s = mem_ack & pend_valid_r[ack_idx_s];

    // Pending valid bits: ack clears first so a same-cycle issue to the same wavefront wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_r <= 64'd0;
        end else begin
            if (ack_hit_s) begin
                pend_valid_r[ack_idx_s] <= 1'b0;
            end
            if (req_valid_s) begin
                pend_valid_r[issue_wfid] <= 1'b1;
            end
        end
    end

    // Pending payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (req_valid_s) begin
            pend_scalar_r[issue_wfid] <= is_smrd_s;
            pend_store_r[issue_wfid]  <= is_store_s;
            pend_dest_r[issue_wfid]   <= issue_dest_reg[9:0];
            pend_exec_r[issue_wfid]   <= exec_exec_value;
            pend_pc_r[issue_wfid]     <= issue_instr_pc;
        end
    end

    // Completion: write-back, done to issue and retirement pulse one cycle after a matching ack
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_mem_done_r      <= 1'b0;
            issue_mem_done_wfid_r <= 6'd0;
            retire_valid_r        <= 1'b0;
            retire_pc_r           <= 32'd0;
            sgpr_dest_wr_en_r     <= 1'b0;
            sgpr_dest_addr_r      <= 9'd0;
            sgpr_dest_data_r      <= 32'd0;
            vgpr_dest_wr_mask_r   <= 64'd0;
            vgpr_dest_addr_r      <= 10'd0;
            vgpr_dest_data_r      <= '0;
        end else begin
            issue_mem_done_r      <= ack_hit_s;
            issue_mem_done_wfid_r <= ack_hit_s ? ack_idx_s : 6'd0;
            retire_valid_r        <= ack_hit_s;
            retire_pc_r           <= ack_hit_s ? pend_pc_r[ack_idx_s] : 32'd0;
            sgpr_dest_wr_en_r     <= 1'b0;
            sgpr_dest_addr_r      <= 9'd0;
            sgpr_dest_data_r      <= 32'd0;
            vgpr_dest_wr_mask_r   <= 64'd0;
            vgpr_dest_addr_r      <= 10'd0;
            vgpr_dest_data_r      <= '0;
            if (ack_hit_s && pend_scalar_r[ack_idx_s]) begin
                sgpr_dest_wr_en_r <= 1'b1;
                sgpr_dest_addr_r  <= pend_dest_r[ack_idx_s][8:0];
                sgpr_dest_data_r  <= mem_rd_data[31:0];
            end else if (ack_hit_s && !pend_store_r[ack_idx_s]) begin
                vgpr_dest_wr_mask_r <= pend_exec_r[ack_idx_s];
                vgpr_dest_addr_r    <= pend_dest_r[ack_idx_s];
                vgpr_dest_data_r    <= mem_rd_data;
            end
        end
    end

    // No backpressure: ready is simply "out of reset"
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_ready_r <= 1'b0;
        end else begin
            issue_ready_r <= 1'b1;
        end
    end

    assign mem_rd_en             = mem_rd_en_r;
    assign mem_wr_en             = mem_wr_en_r;
    assign mem_addr              = mem_addr_r;
    assign mem_wr_data           = mem_wr_data_r;
    assign mem_wr_mask           = mem_wr_mask_r;
    assign lsu2mem_tag           = lsu2mem_tag_r;
    assign vgpr_dest_addr        = vgpr_dest_addr_r;
    assign vgpr_dest_data        = vgpr_dest_data_r;
    assign vgpr_dest_wr_mask     = vgpr_dest_wr_mask_r;
    assign sgpr_dest_addr        = sgpr_dest_addr_r;
    assign sgpr_dest_data        = sgpr_dest_data_r;
    assign sgpr_dest_wr_en       = sgpr_dest_wr_en_r;
    assign issue_mem_done        = issue_mem_done_r;
    assign issue_mem_done_wfid   = issue_mem_done_wfid_r;
    assign issue_ready           = issue_ready_r;
    assign tracemon_retire_valid = retire_valid_r;
    assign tracemon_retire_pc    = retire_pc_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors plus randomized traffic, checked by
// a scoreboard fed from a behavioural model of issue/ack semantics.
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          issue_lsu_select;
    logic [11:0]   issue_source_reg1, issue_source_reg2, issue_source_reg3, issue_dest_reg, issue_mem_sgpr;
    logic [15:0]   issue_imm_value0;
    logic [7:0]    issue_imm_value1;
    logic [15:0]   issue_opdcode;
    logic [5:0]    issue_wfid;
    logic [31:0]   issue_instr_pc;
    logic [2047:0] vgpr_source1_data, vgpr_source2_data, mem_rd_data;
    logic [127:0]  sgpr_source1_data;
    logic [31:0]   sgpr_source2_data;
    logic [63:0]   exec_exec_value;
    logic [6:0]    mem2lsu_tag;
    logic          mem_ack;
    logic [9:0]    vgpr_source1_addr, vgpr_source2_addr, vgpr_dest_addr;
    logic [8:0]    sgpr_source1_addr, sgpr_source2_addr, sgpr_dest_addr;
    logic [5:0]    exec_rd_wfid, issue_mem_done_wfid;
    logic          mem_rd_en, mem_wr_en, sgpr_dest_wr_en, issue_mem_done, issue_ready, tracemon_retire_valid;
    logic [2047:0] mem_addr, mem_wr_data, vgpr_dest_data;
    logic [63:0]   mem_wr_mask, vgpr_dest_wr_mask;
    logic [6:0]    lsu2mem_tag;
    logic [31:0]   sgpr_dest_data, tracemon_retire_pc;

    load_store_unit dut (
        .clk(clk), .rst(rst), .issue_lsu_select(issue_lsu_select),
        .issue_source_reg1(issue_source_reg1), .issue_source_reg2(issue_source_reg2),
        .issue_source_reg3(issue_source_reg3), .issue_dest_reg(issue_dest_reg),
        .issue_mem_sgpr(issue_mem_sgpr), .issue_imm_value0(issue_imm_value0),
        .issue_imm_value1(issue_imm_value1), .issue_opdcode(issue_opdcode),
        .issue_wfid(issue_wfid), .issue_instr_pc(issue_instr_pc),
        .vgpr_source1_data(vgpr_source1_data), .vgpr_source2_data(vgpr_source2_data),
        .sgpr_source1_data(sgpr_source1_data), .sgpr_source2_data(sgpr_source2_data),
        .exec_exec_value(exec_exec_value), .mem_rd_data(mem_rd_data),
        .mem2lsu_tag(mem2lsu_tag), .mem_ack(mem_ack),
        .vgpr_source1_addr(vgpr_source1_addr), .vgpr_source2_addr(vgpr_source2_addr),
        .sgpr_source1_addr(sgpr_source1_addr), .sgpr_source2_addr(sgpr_source2_addr),
        .exec_rd_wfid(exec_rd_wfid), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .lsu2mem_tag(lsu2mem_tag), .vgpr_dest_addr(vgpr_dest_addr),
        .vgpr_dest_data(vgpr_dest_data), .vgpr_dest_wr_mask(vgpr_dest_wr_mask),
        .sgpr_dest_addr(sgpr_dest_addr), .sgpr_dest_data(sgpr_dest_data),
        .sgpr_dest_wr_en(sgpr_dest_wr_en), .issue_mem_done(issue_mem_done),
        .issue_mem_done_wfid(issue_mem_done_wfid), .issue_ready(issue_ready),
        .tracemon_retire_valid(tracemon_retire_valid), .tracemon_retire_pc(tracemon_retire_pc)
    );

    typedef struct {
        int cyc; logic rd; logic wr; logic [6:0] tag;
        logic [2047:0] addr; logic [2047:0] wdata; logic [63:0] mask;
    } req_t;
    typedef struct {
        int cyc; logic [5:0] wfid; logic [31:0] pc; logic sgpr_en; logic [8:0] saddr; logic [31:0] sdata;
        logic vload; logic [63:0] vmask; logic [9:0] vaddr; logic [2047:0] vdata;
    } cmp_t;
    typedef struct {
        logic valid; logic scalar; logic store; logic [9:0] dest; logic [63:0] exec; logic [31:0] pc;
    } pend_t;
    typedef struct {
        logic [5:0] wfid; logic [11:0] src1; logic [11:0] src3; logic [11:0] dest; logic [11:0] msgpr;
        logic [15:0] imm; logic [15:0] opc; logic [31:0] pc; logic [2047:0] v1; logic [2047:0] v2;
        logic [127:0] s1; logic [31:0] s2; logic [63:0] exec;
    } instr_t;

    req_t  req_q[$];
    cmp_t  cmp_q[$];
    pend_t pend[64];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int diff_lane(input logic [2047:0] a, input logic [2047:0] b);
        for (int i = 0; i < 64; i++) if (a[32*i +: 32] !== b[32*i +: 32]) return i;
        return -1;
    endfunction

    task automatic check_wide(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        int l;
        tests++;
        l = diff_lane(act, exp);
        if (l >= 0) begin
            fails++;
            $display("FAIL %s lane %0d actual=%h required=%h", name, l, act[32*l +: 32], exp[32*l +: 32]);
        end
    endtask

    function automatic instr_t blank_instr();
        instr_t i;
        i.wfid = 6'd0; i.src1 = 12'd0; i.src3 = 12'd0; i.dest = 12'd0; i.msgpr = 12'd0;
        i.imm = 16'd0; i.opc = 16'd0; i.pc = 32'd0; i.v1 = '0; i.v2 = '0;
        i.s1 = 128'd0; i.s2 = 32'd0; i.exec = 64'd0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        logic [7:0] cls;
        int pick;
        i = blank_instr();
        pick = int'($urandom_range(0, 9));
        if (pick == 0) cls = 8'h03;
        else if (pick <= 3) cls = 8'h01;
        else cls = 8'h02;
        i.wfid = 6'($urandom_range(0, 7));
        i.opc = {cls, 8'($urandom)};
        i.src1 = 12'($urandom); i.src3 = 12'($urandom); i.dest = 12'($urandom); i.msgpr = 12'($urandom);
        i.imm = 16'($urandom); i.pc = $urandom; i.s2 = $urandom;
        i.exec = {$urandom, $urandom};
        for (int w = 0; w < 4; w++) i.s1[32*w +: 32] = $urandom;
        for (int l = 0; l < 64; l++) begin
            i.v1[32*l +: 32] = $urandom;
            i.v2[32*l +: 32] = $urandom;
        end
        return i;
    endfunction

    // Reference model: what memory should see, and what gets remembered per wavefront
    task automatic model_issue(input instr_t ins);
        req_t  r;
        pend_t p;
        logic [31:0] lane;
        r.cyc = cyc + 1; r.addr = '0; r.wdata = '0;
        p.valid = 1'b1; p.dest = ins.dest[9:0]; p.exec = ins.exec; p.pc = ins.pc;
        if (ins.opc[15:8] == 8'h01) begin
            r.rd = 1'b1; r.wr = 1'b0; r.tag = {1'b1, ins.wfid}; r.mask = 64'h1;
            r.addr[31:0] = ins.s1[31:0] + {16'd0, ins.imm};
            p.scalar = 1'b1; p.store = 1'b0;
            pend[ins.wfid] = p;
            req_q.push_back(r);
        end else if (ins.opc[15:8] == 8'h02) begin
            p.scalar = 1'b0; p.store = ins.opc[2];
            r.rd = !p.store; r.wr = p.store; r.tag = {!p.store, ins.wfid}; r.mask = ins.exec;
            for (int l = 0; l < 64; l++) begin
                lane = ins.s1[31:0] + ins.s2 + ins.v1[32*l +: 32] + {16'd0, ins.imm};
                r.addr[32*l +: 32] = lane;
            end
            if (p.store) r.wdata = ins.v2;
            pend[ins.wfid] = p;
            req_q.push_back(r);
        end
    endtask

    task automatic model_ack(input logic [6:0] tag, input logic [2047:0] data);
        cmp_t c;
        int   idx;
        idx = int'(tag[5:0]);
        if (pend[idx].valid) begin
            c.cyc = cyc + 1; c.wfid = tag[5:0]; c.pc = pend[idx].pc;
            c.sgpr_en = pend[idx].scalar; c.saddr = pend[idx].dest[8:0]; c.sdata = data[31:0];
            c.vload = !pend[idx].scalar && !pend[idx].store;
            c.vmask = c.vload ? pend[idx].exec : 64'd0;
            c.vaddr = pend[idx].dest; c.vdata = data;
            pend[idx].valid = 1'b0;
            cmp_q.push_back(c);
        end
    endtask

    // One stimulus cycle; entered and left at posedge+1
    task automatic drive(input logic sel, input instr_t ins, input logic ack, input logic [6:0] tag,
                         input logic [2047:0] rdata);
        issue_lsu_select = sel; issue_source_reg1 = ins.src1; issue_source_reg2 = 12'd0;
        issue_source_reg3 = ins.src3; issue_dest_reg = ins.dest; issue_mem_sgpr = ins.msgpr;
        issue_imm_value0 = ins.imm; issue_imm_value1 = 8'd0; issue_opdcode = ins.opc;
        issue_wfid = ins.wfid; issue_instr_pc = ins.pc; vgpr_source1_data = ins.v1;
        vgpr_source2_data = ins.v2; sgpr_source1_data = ins.s1; sgpr_source2_data = ins.s2;
        exec_exec_value = ins.exec; mem_ack = ack; mem2lsu_tag = tag; mem_rd_data = rdata;
        if (ack && !rst) model_ack(tag, rdata);
        if (sel && !rst) model_issue(ins);
        #1;
        if (sel) begin
            check("vgpr_src1_addr", 64'(vgpr_source1_addr), 64'(ins.src1[9:0]));
            check("vgpr_src2_addr", 64'(vgpr_source2_addr), 64'(ins.dest[9:0]));
            check("sgpr_src1_addr", 64'(sgpr_source1_addr), 64'(ins.msgpr[8:0]));
            check("sgpr_src2_addr", 64'(sgpr_source2_addr), 64'(ins.src3[8:0]));
            check("exec_rd_wfid", 64'(exec_rd_wfid), 64'(ins.wfid));
        end
        @(posedge clk);
        #1;
        issue_lsu_select = 1'b0;
        mem_ack = 1'b0;
    endtask

    function automatic logic any_output();
        return |{mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask, lsu2mem_tag, vgpr_dest_addr,
                 vgpr_dest_data, vgpr_dest_wr_mask, sgpr_dest_addr, sgpr_dest_data, sgpr_dest_wr_en,
                 issue_mem_done, issue_mem_done_wfid, issue_ready, tracemon_retire_valid, tracemon_retire_pc};
    endfunction

    // Request monitor
    always @(negedge clk) begin : req_mon
        req_t r;
        if (mem_rd_en || mem_wr_en) begin
            if (req_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_request tag=%h rd=%b wr=%b", lsu2mem_tag, mem_rd_en, mem_wr_en);
            end else begin
                r = req_q.pop_front();
                check("req_cycle", 64'(cyc), 64'(r.cyc));
                check("req_rd_en", 64'(mem_rd_en), 64'(r.rd));
                check("req_wr_en", 64'(mem_wr_en), 64'(r.wr));
                check("req_tag", 64'(lsu2mem_tag), 64'(r.tag));
                check("req_mask", mem_wr_mask, r.mask);
                check_wide("req_addr", mem_addr, r.addr);
                if (r.wr) check_wide("req_wr_data", mem_wr_data, r.wdata);
            end
        end else if (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
            tests++; fails++;
            $display("FAIL missing_request actual=none required_tag=%h", req_q[0].tag);
            void'(req_q.pop_front());
        end
    end

    // Completion monitor
    always @(negedge clk) begin : cmp_mon
        cmp_t c;
        if (issue_mem_done) begin
            if (cmp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done wfid=%0d", issue_mem_done_wfid);
            end else begin
                c = cmp_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(c.cyc));
                check("done_wfid", 64'(issue_mem_done_wfid), 64'(c.wfid));
                check("retire_valid", 64'(tracemon_retire_valid), 64'd1);
                check("retire_pc", 64'(tracemon_retire_pc), 64'(c.pc));
                check("sgpr_wr_en", 64'(sgpr_dest_wr_en), 64'(c.sgpr_en));
                check("vgpr_wr_mask", vgpr_dest_wr_mask, c.vmask);
                if (c.sgpr_en) begin
                    check("sgpr_addr", 64'(sgpr_dest_addr), 64'(c.saddr));
                    check("sgpr_data", 64'(sgpr_dest_data), 64'(c.sdata));
                end
                if (c.vload) begin
                    check("vgpr_addr", 64'(vgpr_dest_addr), 64'(c.vaddr));
                    check_wide("vgpr_data", vgpr_dest_data, c.vdata);
                end
            end
        end else if (tracemon_retire_valid || sgpr_dest_wr_en || (|vgpr_dest_wr_mask)) begin
            tests++; fails++;
            $display("FAIL stray_writeback retire=%b sgpr_en=%b vmask=%h", tracemon_retire_valid,
                     sgpr_dest_wr_en, vgpr_dest_wr_mask);
        end else if (cmp_q.size() > 0 && cmp_q[0].cyc <= cyc) begin
            tests++; fails++;
            $display("FAIL missing_done actual=none required_wfid=%0d", cmp_q[0].wfid);
            void'(cmp_q.pop_front());
        end
    end

    initial begin : stim
        instr_t ins;
        logic [2047:0] d;
        for (int i = 0; i < 64; i++) pend[i].valid = 1'b0;
        rst = 1'b1;
        ins = blank_instr();
        issue_lsu_select = 1'b0; mem_ack = 1'b0; mem2lsu_tag = 7'd0; mem_rd_data = '0;
        issue_source_reg1 = 12'd0; issue_source_reg2 = 12'd0; issue_source_reg3 = 12'd0;
        issue_dest_reg = 12'd0; issue_mem_sgpr = 12'd0; issue_imm_value0 = 16'd0; issue_imm_value1 = 8'd0;
        issue_opdcode = 16'd0; issue_wfid = 6'd0; issue_instr_pc = 32'd0; vgpr_source1_data = '0;
        vgpr_source2_data = '0; sgpr_source1_data = 128'd0; sgpr_source2_data = 32'd0; exec_exec_value = 64'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 64'(any_output()), 64'd0);
        check("ready_in_reset", 64'(issue_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(issue_ready), 64'd1);

        // SMRD wfid2
        ins = blank_instr();
        ins.wfid = 6'd2; ins.dest = {2'b11, 10'd16}; ins.msgpr = {2'b11, 10'd4}; ins.imm = 16'd8;
        ins.opc = 16'h0128; ins.pc = 32'd60;
        drive(1'b1, ins, 1'b0, 7'd0, '0);
        check("smrd_tag", 64'(lsu2mem_tag), 64'd66);
        check("smrd_addr0", 64'(mem_addr[31:0]), 64'd8);
        check("smrd_mask", mem_wr_mask, 64'h1);

        // MTBUF load wfid3
        ins = blank_instr();
        ins.wfid = 6'd3; ins.src1 = 12'h804; ins.s1[31:0] = 32'd234; ins.s2 = 32'd98;
        ins.v1[31:0] = 32'd1234; ins.imm = 16'd28; ins.exec = 64'h8888888888444444;
        ins.opc = 16'h0219; ins.dest = {2'b10, 10'd20}; ins.pc = 32'd64;
        drive(1'b1, ins, 1'b0, 7'd0, '0);
        check("ld_tag", 64'(lsu2mem_tag), 64'd67);
        check("ld_rd_en", 64'(mem_rd_en), 64'd1);
        check("ld_addr0", 64'(mem_addr[31:0]), 64'd1594);
        check("ld_addr63", 64'(mem_addr[2047:2016]), 64'd360);

        // MTBUF store wfid4
        ins.wfid = 6'd4; ins.opc = 16'h021C; ins.v2[31:0] = 32'd98765; ins.pc = 32'd128;
        drive(1'b1, ins, 1'b0, 7'd0, '0);
        check("st_tag", 64'(lsu2mem_tag), 64'd4);
        check("st_wr_en", 64'(mem_wr_en), 64'd1);
        check("st_data0", 64'(mem_wr_data[31:0]), 64'd98765);
        check("st_mask", mem_wr_mask, 64'h8888888888444444);

        ins = blank_instr();
        drive(1'b0, ins, 1'b0, 7'd0, '0);
        d = '0; d[31:0] = 32'd222;
        drive(1'b0, ins, 1'b1, 7'd67, d);
        check("ack67_vaddr", 64'(vgpr_dest_addr), 64'd20);
        check("ack67_vmask", vgpr_dest_wr_mask, 64'h8888888888444444);
        check("ack67_wfid", 64'(issue_mem_done_wfid), 64'd3);
        check("ack67_pc", 64'(tracemon_retire_pc), 64'd64);
        drive(1'b0, ins, 1'b1, 7'd4, '0);
        check("ack4_pc", 64'(tracemon_retire_pc), 64'd128);
        d = '0; d[31:0] = 32'd888;
        drive(1'b0, ins, 1'b1, 7'd66, d);
        check("ack66_saddr", 64'(sgpr_dest_addr), 64'd16);
        check("ack66_sdata", 64'(sgpr_dest_data), 64'd888);
        check("ack66_pc", 64'(tracemon_retire_pc), 64'd60);

        // Ack for something never issued, and an unsupported class
        drive(1'b0, ins, 1'b1, 7'd10, '0);
        ins.wfid = 6'd9; ins.opc = 16'h0300;
        drive(1'b1, ins, 1'b0, 7'd0, '0);
        drive(1'b0, ins, 1'b1, 7'd73, '0);

        // Overwrite while pending, with ack in the same cycle
        ins = rand_instr(); ins.wfid = 6'd5; ins.opc = 16'h0210;
        drive(1'b1, ins, 1'b0, 7'd0, '0);
        ins = rand_instr(); ins.wfid = 6'd5; ins.opc = 16'h0100;
        drive(1'b1, ins, 1'b1, 7'd69, {64{32'h0badf00d}});
        drive(1'b0, ins, 1'b1, 7'd69, {64{32'h12345678}});

        // Mid-operation reset drops the pending entry
        ins = rand_instr(); ins.wfid = 6'd6; ins.opc = 16'h0200;
        drive(1'b1, ins, 1'b0, 7'd0, '0);
        drive(1'b0, ins, 1'b0, 7'd0, '0);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) pend[i].valid = 1'b0;
        drive(1'b0, ins, 1'b1, 7'd70, '0);
        check("midop_reset_zero", 64'(any_output()), 64'd0);
        rst = 1'b0;
        drive(1'b0, ins, 1'b1, 7'd70, '0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic sel, ack;
            logic [6:0] tag;
            ins = rand_instr();
            sel = 1'($urandom_range(0, 1));
            ack = 1'($urandom_range(0, 1));
            tag = {1'($urandom), 6'($urandom_range(0, 7))};
            for (int l = 0; l < 64; l++) d[32*l +: 32] = $urandom;
            drive(sel, ins, ack, tag, d);
        end

        ins = blank_instr();
        repeat (3) drive(1'b0, ins, 1'b0, 7'd0, '0);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("done_queue_drained", 64'(cmp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
